interleaver_sequencer: RTL and testbench

Controller that drives the weight/activation interleaver for one junction. It loads the per-sweep starting vectors (sweepstart) through a beat-serial port into flops, replacing the initialise-on-reset constant tables. It then walks cycle_index from 0 to fo*p/z-1 under a valid/ready handshake, flagging sweep boundaries and the end of the junction. It sits between the junction-level control FSM and the combinational interleaver / activation-memory read path.

---
 rtl/interleaver_pkg.sv | 36 +++
 rtl/sweepstart_loader.sv | 56 +++++
 rtl/interleaver_sequencer.sv | 164 ++++++++++++++++
 tb/tb_interleaver_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interleaver_pkg.sv
// Shared definitions for the interleaver datapath and its sequencer:
// FSM state encoding and the width helpers both sides derive their buses from.
package interleaver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  // Bits needed to name one chunk (a value in 0 .. p/z-1).
  function automatic int cw_f(input int p, input int z);
    return $clog2(p / z);
  endfunction

  // One seed beat: z chunks packed side by side.
  function automatic int bw_f(input int p, input int z);
    return z * cw_f(p, z);
  endfunction

  // Full sweepstart vector: one beat per sweep.
  function automatic int sw_f(input int fo, input int p, input int z);
    return fo * bw_f(p, z);
  endfunction

  // Width of the cycle counter that walks 0 .. fo*p/z-1.
  function automatic int ciw_f(input int fo, input int p, input int z);
    return $clog2((fo * p) / z);
  endfunction

  // Width of the sweep number; kept at least one bit wide for fo=1.
  function automatic int snw_f(input int fo);
    return (fo > 1) ? $clog2(fo) : 1;
  endfunction

endpackage

// File: rtl/sweepstart_loader.sv
// Beat-serial loader for the per-sweep starting vectors. Each accepted beat
// lands in its own BW-wide slot of the sweepstart register; seed_loaded rises
// once the last slot has been written.
module sweepstart_loader
  import interleaver_pkg::*;
#(
  parameter int fo = 2,
  parameter int p  = 32,
  parameter int z  = 8,
  localparam int BW  = bw_f(p, z),
  localparam int SW  = sw_f(fo, p, z),
  localparam int BNW = snw_f(fo)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          in_load,
  input  logic          seed_valid,
  input  logic [BW-1:0] seed_data,
  output logic          seed_ready,
  output logic          last_beat,
  output logic          seed_loaded,
  output logic [SW-1:0] sweepstart
);

  logic [BNW-1:0] beat_r;
  logic [SW-1:0]  sweepstart_r;
  logic           seed_loaded_r;
  logic           accept_s;

  assign seed_ready = in_load;
  assign accept_s   = in_load & seed_valid;
  assign last_beat  = accept_s & (beat_r == BNW'(fo - 1));

  // Beat counter, slot write and completion flag; a new load invalidates the old seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_r        <= '0;
      sweepstart_r  <= '0;
      seed_loaded_r <= 1'b0;
    end else if (load_start) begin
      beat_r        <= '0;
      seed_loaded_r <= 1'b0;
    end else if (accept_s) begin
      sweepstart_r[int'(beat_r) * BW +: BW] <= seed_data;
      beat_r <= beat_r + BNW'(1);
      if (last_beat) begin
        seed_loaded_r <= 1'b1;
      end
    end
  end

  assign seed_loaded = seed_loaded_r;
  assign sweepstart  = sweepstart_r;

endmodule

// File: rtl/interleaver_sequencer.sv
// Junction sequencer: loads the sweepstart seed, then walks cycle_index over
// one junction pass under a valid/ready handshake, decoding sweep boundaries
// and the final index for the interleaver read path.
module interleaver_sequencer
  import interleaver_pkg::*;
#(
  parameter int fo = 2,
  parameter int p  = 32,
  parameter int z  = 8,
  localparam int CW   = cw_f(p, z),
  localparam int BW   = bw_f(p, z),
  localparam int SW   = sw_f(fo, p, z),
  localparam int CIW  = ciw_f(fo, p, z),
  localparam int SNW  = snw_f(fo),
  localparam int NCYC = (fo * p) / z
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           seed_load,
  input  logic           seed_valid,
  input  logic [BW-1:0]  seed_data,
  output logic           seed_ready,
  input  logic           start,
  input  logic           abort,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [CIW-1:0] cycle_index,
  output logic [SNW-1:0] sweep_num,
  output logic           first_of_sweep,
  output logic           last_of_junction,
  output logic [SW-1:0]  sweepstart,
  output logic           seed_loaded,
  output logic           busy,
  output logic           done,
  output logic           err_no_seed
);

  seq_state_t     state_r, state_s;
  logic [CIW-1:0] cycle_index_r, cycle_index_s;
  logic           done_r, done_s;
  logic           err_r, err_s;
  logic           load_start_s;
  logic           last_beat_s;
  logic           in_load_s;
  logic           out_valid_s;
  logic           handshake_s;
  logic           last_s;

  assign in_load_s   = (state_r == LOAD);
  assign out_valid_s = (state_r == RUN);
  assign handshake_s = out_valid_s & out_ready;
  assign last_s      = (cycle_index_r == CIW'(NCYC - 1));

  sweepstart_loader #(
    .fo (fo),
    .p  (p),
    .z  (z)
  ) u_loader (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start_s),
    .in_load     (in_load_s),
    .seed_valid  (seed_valid),
    .seed_data   (seed_data),
    .seed_ready  (seed_ready),
    .last_beat   (last_beat_s),
    .seed_loaded (seed_loaded),
    .sweepstart  (sweepstart)
  );

  // Next-state, cycle counter and pulse decode; abort outranks a same-cycle handshake.
  always_comb begin
    state_s       = state_r;
    cycle_index_s = cycle_index_r;
    done_s        = 1'b0;
    err_s         = 1'b0;
    load_start_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (seed_load) begin
          state_s      = LOAD;
          load_start_s = 1'b1;
        end else if (start) begin
          if (seed_loaded) begin
            state_s       = RUN;
            cycle_index_s = '0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (last_beat_s) begin
          state_s = IDLE;
        end else begin
          state_s = LOAD;
        end
      end
      RUN: begin
        if (abort) begin
          state_s       = IDLE;
          cycle_index_s = '0;
        end else if (handshake_s) begin
          if (last_s) begin
            state_s       = IDLE;
            cycle_index_s = '0;
            done_s        = 1'b1;
          end else begin
            cycle_index_s = cycle_index_r + CIW'(1);
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s       = IDLE;
        cycle_index_s = '0;
      end
    endcase
  end

  // State, counter and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      cycle_index_r <= '0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      cycle_index_r <= cycle_index_s;
      done_r        <= done_s;
      err_r         <= err_s;
    end
  end

  // Sweep number is the top index bits; a single-sweep junction is always sweep 0.
  generate
    if (fo > 1) begin : g_sweep_num
      assign sweep_num = cycle_index_r[CIW-1 -: $clog2(fo)];
    end else begin : g_sweep_zero
      assign sweep_num = '0;
    end
  endgenerate

  // A sweep begins whenever the chunk-position bits of the index are zero.
  generate
    if (CW > 0) begin : g_first
      assign first_of_sweep = out_valid_s & (cycle_index_r[CW-1:0] == CW'(0));
    end else begin : g_first_all
      assign first_of_sweep = out_valid_s;
    end
  endgenerate

  assign last_of_junction = out_valid_s & last_s;
  assign out_valid        = out_valid_s;
  assign cycle_index      = cycle_index_r;
  assign busy             = (state_r != IDLE);
  assign done             = done_r;
  assign err_no_seed      = err_r;

endmodule

// File: tb/tb_interleaver_sequencer.sv
// Scoreboard bench for interleaver_sequencer (fo=2, p=32, z=8).
// Stimulus pushes expected stream entries and done events; a negedge monitor
// compares every presented output against the queue head.
module tb_interleaver_sequencer;

  localparam int BW  = 16;
  localparam int SW  = 32;
  localparam int CIW = 3;
  localparam int SNW = 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           seed_load = 1'b0;
  logic           seed_valid = 1'b0;
  logic [BW-1:0]  seed_data = '0;
  logic           seed_ready;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [CIW-1:0] cycle_index;
  logic [SNW-1:0] sweep_num;
  logic           first_of_sweep;
  logic           last_of_junction;
  logic [SW-1:0]  sweepstart;
  logic           seed_loaded;
  logic           busy;
  logic           done;
  logic           err_no_seed;

  interleaver_sequencer #(.fo(2), .p(32), .z(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .seed_load        (seed_load),
    .seed_valid       (seed_valid),
    .seed_data        (seed_data),
    .seed_ready       (seed_ready),
    .start            (start),
    .abort            (abort),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .cycle_index      (cycle_index),
    .sweep_num        (sweep_num),
    .first_of_sweep   (first_of_sweep),
    .last_of_junction (last_of_junction),
    .sweepstart       (sweepstart),
    .seed_loaded      (seed_loaded),
    .busy             (busy),
    .done             (done),
    .err_no_seed      (err_no_seed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int sn;
    int first;
    int last;
  } exp_t;

  exp_t q[$];
  int   done_exp = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Hand-written expectations for one pass of 8 indices.
  int sn_tab[8]    = '{0, 0, 0, 0, 1, 1, 1, 1};
  int first_tab[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  int last_tab[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entries(input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back('{i, sn_tab[i], first_tab[i], last_tab[i]});
    end
  endtask

  // Stream monitor: compare every presented index, retire it on handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        check("stream_unexpected_valid", {61'd0, cycle_index}, 64'hFFFF);
      end else begin
        check("cycle_index", {61'd0, cycle_index}, q[0].idx);
        check("sweep_num", {63'd0, sweep_num}, q[0].sn);
        check("first_of_sweep", {63'd0, first_of_sweep}, q[0].first);
        check("last_of_junction", {63'd0, last_of_junction}, q[0].last);
        if (out_ready) begin
          void'(q.pop_front());
        end
      end
    end
    if (!reset && done) begin
      if (done_exp > 0) begin
        done_exp--;
        n_checks++;
      end else begin
        check("done_unexpected", 64'd1, 64'd0);
      end
    end
  end

  // Load two beats; optionally raise start together with seed_load.
  task automatic load_seed(input logic [15:0] b0, input logic [15:0] b1, input bit with_start);
    seed_load = 1'b1;
    start     = with_start;
    tick();
    seed_load = 1'b0;
    start     = 1'b0;
    check("load_seed_ready_beat0", {63'd0, seed_ready}, 64'd1);
    check("load_busy", {63'd0, busy}, 64'd1);
    check("load_no_err", {63'd0, err_no_seed}, 64'd0);
    seed_valid = 1'b1;
    seed_data  = b0;
    tick();
    check("load_seed_ready_beat1", {63'd0, seed_ready}, 64'd1);
    check("load_not_yet_loaded", {63'd0, seed_loaded}, 64'd0);
    seed_data = b1;
    tick();
    seed_valid = 1'b0;
    check("load_seed_ready_done", {63'd0, seed_ready}, 64'd0);
    check("load_seed_loaded", {63'd0, seed_loaded}, 64'd1);
    check("load_sweepstart", {32'd0, sweepstart}, {32'd0, b1, b0});
  endtask

  // One full pass; out_ready drops for stall_len cycles starting at cycle stall_from.
  task automatic run_pass(input int stall_from, input int stall_len, input int exp_lat);
    int cnt;
    push_entries(8);
    done_exp++;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    cnt   = 1;
    while (cnt < 60) begin
      if (done) break;
      if (stall_len > 0 && cnt >= stall_from && cnt < stall_from + stall_len) out_ready = 1'b0;
      else out_ready = 1'b1;
      if (stall_len > 0 && cnt == stall_from + stall_len - 1) begin
        check("stall_index_held", {61'd0, cycle_index}, stall_from - 1);
        check("stall_valid_held", {63'd0, out_valid}, 64'd1);
      end
      if (cnt == exp_lat - 1) begin
        check("busy_before_done", {63'd0, busy}, 64'd1);
      end
      tick();
      cnt++;
    end
    check("done_latency", cnt, exp_lat);
    check("busy_with_done", {63'd0, busy}, 64'd0);
    check("index_back_to_zero", {61'd0, cycle_index}, 64'd0);
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_seed_ready", {63'd0, seed_ready}, 64'd0);
    check("rst_sweepstart", {32'd0, sweepstart}, 64'd0);
    check("rst_seed_loaded", {63'd0, seed_loaded}, 64'd0);
    check("rst_cycle_index", {61'd0, cycle_index}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);

    // Start without a seed: error pulse, stays idle.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_no_seed_pulse", {63'd0, err_no_seed}, 64'd1);
    check("err_busy", {63'd0, busy}, 64'd0);
    check("err_no_valid", {63'd0, out_valid}, 64'd0);
    tick();
    check("err_pulse_ends", {63'd0, err_no_seed}, 64'd0);

    // Plain load from the test plan.
    load_seed(16'h2D82, 16'h8772, 1'b0);

    // Free-running pass: done 9 cycles after start.
    run_pass(0, 0, 9);

    // Backpressure at index 3 for 5 cycles: done 14 cycles after start.
    run_pass(4, 5, 14);

    // Abort at index 5.
    push_entries(6);
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort_at_index5", {61'd0, cycle_index}, 64'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid_low", {63'd0, out_valid}, 64'd0);
    check("abort_busy_low", {63'd0, busy}, 64'd0);
    check("abort_no_done", {63'd0, done}, 64'd0);
    check("abort_keeps_loaded", {63'd0, seed_loaded}, 64'd1);
    tick();
    run_pass(0, 0, 9);
    check("restart_sweepstart", {32'd0, sweepstart}, 64'h87722D82);

    // seed_load and start together: load wins, no error.
    load_seed(16'h1234, 16'hFEDC, 1'b1);

    // Reset after the first beat of a reload discards everything.
    seed_load = 1'b1;
    tick();
    seed_load  = 1'b0;
    seed_valid = 1'b1;
    seed_data  = 16'hAAAA;
    tick();
    seed_valid = 1'b0;
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    check("midload_rst_sweepstart", {32'd0, sweepstart}, 64'd0);
    check("midload_rst_loaded", {63'd0, seed_loaded}, 64'd0);
    check("midload_rst_busy", {63'd0, busy}, 64'd0);
    check("midload_rst_ready", {63'd0, seed_ready}, 64'd0);
    tick();
    load_seed(16'h2D82, 16'h8772, 1'b0);
    run_pass(0, 0, 9);

    repeat (3) tick();
    check("stream_queue_drained", q.size(), 64'd0);
    check("done_events_seen", done_exp, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
